// File: rtl/sprite_palette_encoder.sv
// sprite_palette_encoder: turns raster 6-bit colour pixels of an 18x18 tile into 3-bit indexed rows plus a palette/slot word.
// Define SPRITE_ENC_TRANSPARENT_EN to reserve palette entry 0 for transparent black.
module sprite_palette_encoder #(
    parameter int WIDTH  = 18,
    parameter int HEIGHT = 18
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           Tile,
    input  logic                 PixValid,
    input  logic [5:0]           PixData,
    output logic                 PixReady,
    output logic                 RowValid,
    input  logic                 RowReady,
    output logic [4:0]           RowIdx,
    output logic [3*WIDTH-1:0]   RowBits,
    output logic                 WordValid,
    input  logic                 WordReady,
    output logic [49:0]          Word,
    output logic                 Overflow
);
`ifdef SPRITE_ENC_TRANSPARENT_EN
    localparam logic [3:0] USED_INIT = 4'd1;
`else
    localparam logic [3:0] USED_INIT = 4'd0;
`endif
    localparam int PW = $clog2(3 * WIDTH);

    typedef enum logic [1:0] {IDLE, ACCEPT, ROW_OUT, WORD_OUT} state_t;

    state_t             state_q, state_d;
    logic [4:0]         x_q, x_d, row_idx_q, row_idx_d;
    logic [3*WIDTH-1:0] row_bits_q, row_bits_d;
    logic [7:0][5:0]    pal_q, pal_d;
    logic [3:0]         used_q, used_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         tile_q, tile_d;
    logic               pix_ready_q, pix_ready_d;
    logic               row_valid_q, row_valid_d;
    logic               word_valid_q, word_valid_d;
    logic               hit;
    logic [2:0]         hit_idx, pix_idx;
    logic [PW-1:0]      pos;

    // Lookup only sees the registered palette; a miss inserts into that same register, so the next pixel hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (!hit && 4'(i) < used_q && pal_q[i] == PixData) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        row_idx_d  = row_idx_q;
        row_bits_d = row_bits_q;
        pal_d      = pal_q;
        used_d     = used_q;
        ovf_d      = ovf_q;
        tile_d     = tile_q;
        pix_idx    = hit ? hit_idx : (used_q[3] ? 3'd0 : used_q[2:0]);
        pos        = PW'(3 * (WIDTH - 1 - int'(x_q)));
        case (state_q)
            IDLE, ACCEPT: if (PixValid) begin
                tile_d = (state_q == IDLE) ? Tile : tile_q;
                if (!hit && !used_q[3]) begin
                    pal_d[used_q[2:0]] = PixData;
                    used_d             = used_q + 4'd1;
                end
                ovf_d                  = ovf_q | (!hit & used_q[3]);
                row_bits_d[pos +: 3]   = pix_idx;
                x_d                    = (x_q == 5'(WIDTH - 1)) ? 5'd0 : x_q + 5'd1;
                state_d                = (x_q == 5'(WIDTH - 1)) ? ROW_OUT : ACCEPT;
            end
            ROW_OUT: if (RowReady) begin
                state_d   = (row_idx_q == 5'(HEIGHT - 1)) ? WORD_OUT : ACCEPT;
                row_idx_d = (row_idx_q == 5'(HEIGHT - 1)) ? row_idx_q : row_idx_q + 5'd1;
            end
            default: if (WordReady) begin
                pal_d     = '0;
                used_d    = USED_INIT;
                ovf_d     = 1'b0;
                x_d       = 5'd0;
                row_idx_d = 5'd0;
                state_d   = IDLE;
            end
        endcase
        pix_ready_d  = state_d == IDLE || state_d == ACCEPT;
        row_valid_d  = state_d == ROW_OUT;
        word_valid_d = state_d == WORD_OUT;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            x_q          <= 5'd0;
            row_idx_q    <= 5'd0;
            row_bits_q   <= '0;
            pal_q        <= '0;
            used_q       <= USED_INIT;
            ovf_q        <= 1'b0;
            tile_q       <= 2'd0;
            pix_ready_q  <= 1'b1;
            row_valid_q  <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            row_idx_q    <= row_idx_d;
            row_bits_q   <= row_bits_d;
            pal_q        <= pal_d;
            used_q       <= used_d;
            ovf_q        <= ovf_d;
            tile_q       <= tile_d;
            pix_ready_q  <= pix_ready_d;
            row_valid_q  <= row_valid_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign PixReady  = pix_ready_q;
    assign RowValid  = row_valid_q;
    assign WordValid = word_valid_q;
    assign RowIdx    = row_idx_q;
    assign RowBits   = row_bits_q;
    assign Word      = {pal_q, tile_q};
    assign Overflow  = ovf_q;
endmodule

// File: tb/tb_sprite_palette_encoder.sv
// tb_sprite_palette_encoder: directed tiles checked every cycle against a palette-list model, plus literal pins.
module tb_sprite_palette_encoder;
    localparam int W = 18;
    localparam int H = 18;

`ifdef SPRITE_ENC_TRANSPARENT_EN
    localparam logic [49:0] UNI_WORD = {36'h0, 6'h15, 6'h00, 2'b10};
    localparam logic [53:0] UNI_ROW  = {18{3'b001}};
    localparam logic [49:0] OVF_WORD = {6'h07, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00, 2'b01};
    localparam logic [2:0]  OVF_8TH  = 3'd0;
    localparam logic [49:0] BP_WORD  = {18'h0, 6'h23, 6'h22, 6'h21, 6'h20, 6'h00, 2'b00};
    localparam logic [49:0] RST_WORD = {36'h0, 6'h2A, 6'h00, 2'b01};
    localparam logic [49:0] B2B_W1   = {12'h0, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00, 2'b01};
    localparam logic [49:0] B2B_W2   = {30'h0, 6'h31, 6'h30, 6'h00, 2'b11};
`else
    localparam logic [49:0] UNI_WORD = {42'h0, 6'h15, 2'b10};
    localparam logic [53:0] UNI_ROW  = 54'h0;
    localparam logic [49:0] OVF_WORD = {6'h08, 6'h07, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 2'b01};
    localparam logic [2:0]  OVF_8TH  = 3'd7;
    localparam logic [49:0] BP_WORD  = {24'h0, 6'h23, 6'h22, 6'h21, 6'h20, 2'b00};
    localparam logic [49:0] RST_WORD = {42'h0, 6'h2A, 2'b01};
    localparam logic [49:0] B2B_W1   = {18'h0, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 2'b01};
    localparam logic [49:0] B2B_W2   = {36'h0, 6'h31, 6'h30, 2'b11};
`endif
    localparam logic [49:0] PO_WORD  = {30'h0, 6'h07, 6'h3F, 6'h00, 2'b00};

    logic        Clk = 1'b0, Reset = 1'b1;
    logic [1:0]  Tile = 2'd0;
    logic        PixValid = 1'b0;
    logic [5:0]  PixData = 6'd0;
    logic        PixReady, RowValid, WordValid, Overflow;
    logic        RowReady = 1'b1, WordReady = 1'b1;
    logic [4:0]  RowIdx;
    logic [53:0] RowBits;
    logic [49:0] Word;

    sprite_palette_encoder dut (
        .Clk(Clk), .Reset(Reset), .Tile(Tile), .PixValid(PixValid), .PixData(PixData),
        .PixReady(PixReady), .RowValid(RowValid), .RowReady(RowReady), .RowIdx(RowIdx),
        .RowBits(RowBits), .WordValid(WordValid), .WordReady(WordReady), .Word(Word),
        .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {int idx; logic [53:0] bits;} row_t;
    typedef struct {logic [49:0] word; logic ovf;} word_t;
    row_t        exp_rows[$];
    word_t       exp_words[$];
    logic [5:0]  colours[$];
    logic [2:0]  m_idx[W];
    logic        m_ovf;
    logic [1:0]  m_tile;
    int          m_x, m_row, m_npix;

    logic [49:0] got_words[$];
    logic        last_ovf;
    logic [53:0] row0_bits;
    int          rows_tile, last_rows, stall_cnt, t_first, tile_cycles, t_word_hs, first_gap;

    task automatic model_clear();
        colours.delete();
`ifdef SPRITE_ENC_TRANSPARENT_EN
        colours.push_back(6'h00);
`endif
        m_ovf  = 1'b0;
        m_x    = 0;
        m_row  = 0;
        m_npix = 0;
    endtask

    task automatic model_pixel(input logic [5:0] c);
        int k = -1;
        foreach (colours[i]) if (k < 0 && colours[i] == c) k = i;
        if (k < 0) begin
            if (colours.size() < 8) begin
                colours.push_back(c);
                k = colours.size() - 1;
            end else begin
                k = 0;
                m_ovf = 1'b1;
            end
        end
        if (m_npix == 0) m_tile = Tile;
        m_idx[m_x] = 3'(k);
        m_npix++;
        if (m_x == W - 1) begin
            row_t r;
            r.idx  = m_row;
            r.bits = '0;
            for (int x = 0; x < W; x++) r.bits = {r.bits[50:0], m_idx[x]};
            exp_rows.push_back(r);
            m_x = 0;
            m_row++;
        end else m_x++;
    endtask

    task automatic push_word();
        word_t wv;
        wv.word = {48'h0, m_tile};
        for (int c = 0; c < 8; c++)
            if (c < colours.size()) wv.word = wv.word | (50'(colours[c]) << (6 * c + 2));
        wv.ovf = m_ovf;
        exp_words.push_back(wv);
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            model_clear();
            exp_rows.delete();
            exp_words.delete();
            rows_tile = 0;
        end else begin
            chk("pix_ready", PixReady, exp_rows.size() == 0 && exp_words.size() == 0);
            chk("row_valid", RowValid, exp_rows.size() != 0);
            chk("word_valid", WordValid, exp_words.size() != 0);
            if (RowValid && exp_rows.size() != 0) begin
                chk("row_idx", RowIdx, exp_rows[0].idx);
                chk("row_bits", RowBits, exp_rows[0].bits);
            end
            if (WordValid && exp_words.size() != 0) begin
                chk("word", Word, exp_words[0].word);
                chk("overflow", Overflow, exp_words[0].ovf);
            end
            if (RowValid && !RowReady) stall_cnt++;
            if (PixValid && PixReady) begin
                if (m_npix == 0) begin
                    t_first   = cyc;
                    first_gap = cyc - t_word_hs;
                end
                model_pixel(PixData);
            end
            if (RowValid && RowReady && exp_rows.size() != 0) begin
                if (exp_rows[0].idx == 0) row0_bits = RowBits;
                rows_tile++;
                if (exp_rows[0].idx == H - 1) push_word();
                void'(exp_rows.pop_front());
            end
            if (WordValid && WordReady && exp_words.size() != 0) begin
                got_words.push_back(Word);
                last_ovf    = Overflow;
                last_rows   = rows_tile;
                rows_tile   = 0;
                tile_cycles = cyc - t_first;
                t_word_hs   = cyc;
                void'(exp_words.pop_front());
                model_clear();
            end
        end
    end

    function automatic logic [5:0] pix(input int kind, input int n);
        int x = n % W, y = n / W;
        case (kind)
            0: return 6'h15;
            1: return (n == 1 || n == 2) ? 6'h3F : (n == 3 ? 6'h07 : 6'h00);
            2: return n < 9 ? 6'(n + 1) : 6'h01;
            3: return 6'h20 + 6'((x + y) % 4);
            4: return 6'h2A;
            5: return 6'(x % 5 + 1);
            6: return (y % 2 == 0) ? 6'h30 : 6'h31;
            default: return 6'(n % 10 + 1);
        endcase
    endfunction

    task automatic send_px(input logic [5:0] c);
        int n = 0;
        PixValid = 1'b1;
        PixData  = c;
        while (!PixReady && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!PixReady) chk("pix_ready_wait", PixReady, 1'b1);
        @(posedge Clk); #1;
    endtask

    task automatic run_tile(input logic [1:0] t, input int kind);
        Tile = t;
        for (int n = 0; n < W * H; n++) send_px(pix(kind, n));
    endtask

    task automatic wait_word(input int n_before);
        int n = 0;
        while (got_words.size() == n_before && n < 60) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("word_arrived", got_words.size(), n_before + 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_pix_ready", PixReady, 1'b1);
        chk("rst_row_valid", RowValid, 1'b0);
        chk("rst_word_valid", WordValid, 1'b0);
        chk("rst_row_idx", RowIdx, 5'd0);
        chk("rst_row_bits", RowBits, 54'd0);
        chk("rst_word", Word, 50'd0);
        chk("rst_overflow", Overflow, 1'b0);
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset_vals();
        Reset = 1'b0;
        @(posedge Clk); #1;

        n0 = got_words.size();
        run_tile(2'd2, 0);
        PixValid = 1'b0;
        wait_word(n0);
        chk("uni_word", got_words[$], UNI_WORD);
        chk("uni_ovf", last_ovf, 1'b0);
        chk("uni_row0", row0_bits, UNI_ROW);
        chk("uni_rows", last_rows, 18);
        chk("uni_cycles", tile_cycles, 342);

        n0 = got_words.size();
        run_tile(2'd0, 1);
        PixValid = 1'b0;
        wait_word(n0);
        chk("order_row0", row0_bits[53:42], 12'b000_001_001_010);
        chk("order_word", got_words[$], PO_WORD);

        n0 = got_words.size();
        run_tile(2'd1, 2);
        PixValid = 1'b0;
        wait_word(n0);
        chk("ovf_ninth", row0_bits[29:27], 3'd0);
        chk("ovf_eighth", row0_bits[32:30], OVF_8TH);
        chk("ovf_flag", last_ovf, 1'b1);
        chk("ovf_word", got_words[$], OVF_WORD);

        n0 = got_words.size();
        stall_cnt = 0;
        Tile = 2'd0;
        for (int n = 0; n < W * H; n++) begin
            send_px(pix(3, n));
            if (n == 4 * W - 1) begin
                RowReady = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge Clk); #1;
                    chk("stall_pix_ready", PixReady, 1'b0);
                    chk("stall_row_idx", RowIdx, 5'd3);
                end
                RowReady = 1'b1;
            end
        end
        PixValid = 1'b0;
        wait_word(n0);
        chk("bp_stall_cycles", stall_cnt, 5);
        chk("bp_rows", last_rows, 18);
        chk("bp_word", got_words[$], BP_WORD);
        chk("bp_ovf", last_ovf, 1'b0);

        Tile = 2'd2;
        for (int n = 0; n < 100; n++) send_px(pix(7, n));
        Reset    = 1'b1;
        PixValid = 1'b0;
        #2;
        check_reset_vals();
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        n0 = got_words.size();
        run_tile(2'd1, 4);
        PixValid = 1'b0;
        wait_word(n0);
        chk("rst_tile_word", got_words[$], RST_WORD);
        chk("rst_tile_ovf", last_ovf, 1'b0);
        chk("rst_tile_rows", last_rows, 18);

        n0 = got_words.size();
        run_tile(2'd1, 5);
        run_tile(2'd3, 6);
        PixValid = 1'b0;
        wait_word(n0 + 1);
        chk("b2b_word1", got_words[n0], B2B_W1);
        chk("b2b_word2", got_words[n0 + 1], B2B_W2);
        chk("b2b_gap", first_gap, 1);
        chk("b2b_ovf", last_ovf, 1'b0);

        repeat (3) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sprite_palette_encoder.md
# sprite_palette_encoder

Streaming encoder that produces the packed sprite format consumed by the sprite ROMs: 18 bitmap rows of 3-bit palette indices plus one 50-bit VRAM word (eight 6-bit palette colours and a 2-bit tile slot). It accepts raw 6-bit colour pixels for one 18x18 tile in raster order and builds the palette on the fly. It emits each encoded row as soon as that row completes, then emits the VRAM word. It sits in the asset/load path and feeds a writable sprite store.

## Interface
- WIDTH, 18, pixels per row; bitmap row width is 3*WIDTH.
- HEIGHT, 18, rows per tile.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tile  in  2  tile slot; sampled on the first accepted pixel of a tile.
- PixValid  in  1  PixData is valid.
- PixData  in  6  pixel colour.
- PixReady  out  1  encoder accepts a pixel this cycle.
- RowValid  out  1  RowBits/RowIdx are valid.
- RowReady  in  1  downstream takes the row.
- RowIdx  out  5  row number, 0..HEIGHT-1.
- RowBits  out  54  packed indices; pixel X at bits [3*(WIDTH-1-X) +: 3].
- WordValid  out  1  Word is valid.
- WordReady  in  1  downstream takes the word.
- Word  out  50  palette colour c at bits [6c+2 +: 6]; bits [1:0] = latched Tile.
- Overflow  out  1  more than 8 distinct colours were seen in the current tile; valid with WordValid.

## Operation
- The FSM has four states: IDLE, ACCEPT, ROW_OUT and WORD_OUT.
- IDLE:
  - PixReady=1.
  - The first handshake latches Tile, processes the pixel as in ACCEPT, and moves to ACCEPT.
- ACCEPT:
  - PixReady=1.
  - On each handshake, PixData is compared in parallel against the `used` palette entries.
  - On a hit, the matching index is used.
  - On a miss with fewer than 8 entries used, the colour is written to the next free entry, that index is used, and the used count is incremented.
  - On a miss with 8 entries used, index 0 is used and the sticky Overflow flag is set.
  - The index is written into the row shift register at position X. X then increments.
  - On the pixel with X=WIDTH-1, the row is complete: X wraps to 0 and the FSM goes to ROW_OUT.
- ROW_OUT:
  - PixReady=0, RowValid=1; RowBits and RowIdx are held stable.
  - On a RowReady handshake, if RowIdx=HEIGHT-1 the FSM goes to WORD_OUT.
  - Otherwise RowIdx increments and the FSM returns to ACCEPT.
- WORD_OUT:
  - PixReady=0, WordValid=1; Word and Overflow are held stable.
  - Unused palette entries read as 6'b000000.
  - On a WordReady handshake, the palette, used count, Overflow, X and RowIdx are cleared and the FSM goes to IDLE.
- A palette hit check and a new-entry insert in the same cycle must not collide. The pixel that consumes a new entry sees its own insert, and the next pixel must hit on that colour.
- Reset mid-tile aborts the tile; no partial row or word is emitted.

## Timing
- Reset values:
  - PixReady=1.
  - RowValid=0, WordValid=0.
  - RowIdx=0, RowBits=0, Word=0, Overflow=0.
  - FSM in IDLE; palette all zero.
- Input throughput is one pixel per cycle within a row.
- RowValid asserts in the cycle after the last pixel of a row is accepted. With RowReady held high it stays high for 1 cycle, and PixReady rises in the following cycle.
- With RowReady and WordReady tied high, one tile takes 18*18 + 18 + 1 = 343 cycles minimum.
- RowValid and WordValid, once asserted, stay high with stable data until their ready signal is seen. They never deassert without a handshake.
- Tile and PixData changes while PixReady=0 are ignored.

## Configuration
- SPRITE_ENC_TRANSPARENT_EN
- Defined:
  - Palette index 0 is pre-seeded with colour 6'b000000 (transparent) at reset and after each word handshake, with used=1.
  - Black/transparent pixels always encode to index 0.
  - Only 7 further distinct colours fit before Overflow.
- Undefined:
  - The palette starts empty (used=0).
  - The first distinct colour gets index 0, including 6'b000000.
  - 8 distinct colours fit.

## Test plan
- **Uniform tile (macro undefined):** 324 pixels of 6'h15, tile 2, ready signals high.
  - 18 rows with RowBits=0, RowIdx 0..17.
  - Word=(6'h15<<2)|2'b10, Overflow=0.
- **Palette order (macro defined):** row 0 = 6'h00, 6'h3F, 6'h3F, 6'h07, then 6'h00 for the rest of the tile.
  - Row 0 RowBits[53:42]=12'b000_001_001_010.
  - Word palette = {0, 3F, 07, 0...}.
- **Overflow:** 9 distinct colours 6'h01..6'h09 at the start of row 0 (macro undefined).
  - The ninth pixel encodes to 0.
  - Overflow=1 with WordValid; Word palette = 01..08.
- **Back-pressure:** RowReady low for 5 cycles after row 3.
  - RowValid and RowBits are stable for the whole stall.
  - PixReady=0 during the stall, and no pixel is lost.
  - Pixel count and row count stay exact.
- **Reset mid-tile:** assert Reset after 100 pixels, then stream a full tile of 6'h2A.
  - All outputs return to their reset values.
  - The new tile encodes cleanly with no Overflow and no stale palette entries.
- **Back-to-back tiles:** tile 1 then tile 3, with no idle cycles between them.
  - The second Word carries slot 2'b11 and only the second tile's colours.
